// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID decoupling queue.
package ifid_pkg;

    localparam int IFID_XLEN = 32;

    localparam logic [IFID_XLEN-1:0] NOP_INSTR   = 32'h00000013;
    localparam logic [IFID_XLEN-1:0] ECALL_INSTR = 32'h00000073;

    typedef struct packed {
        logic [IFID_XLEN-1:0] pc;
        logic [IFID_XLEN-1:0] pc_plus4;
        logic [IFID_XLEN-1:0] instr;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID queue.
// master: the core side driving fetch data, flush and decode ready.
// slave: the queue itself.
interface ifid_queue_if #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
);
    logic                         fetch_valid;
    logic [XLEN-1:0]              PC_IFID_in;
    logic [XLEN-1:0]              PC_plus4_IFID_in;
    logic [XLEN-1:0]              instruction_IFID_in;
    logic                         fetch_ready;
    logic                         flush;
    logic                         id_ready;
    logic                         id_valid;
    logic [XLEN-1:0]              PC_IFID_out;
    logic [XLEN-1:0]              PC_plus4_IFID_out;
    logic [XLEN-1:0]              instruction_IFID_out;
    logic                         ecall_halt;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output fetch_valid, PC_IFID_in, PC_plus4_IFID_in, instruction_IFID_in,
        output flush, id_ready,
        input  fetch_ready, id_valid, PC_IFID_out, PC_plus4_IFID_out,
        input  instruction_IFID_out, ecall_halt, occupancy
    );

    modport slave (
        input  fetch_valid, PC_IFID_in, PC_plus4_IFID_in, instruction_IFID_in,
        input  flush, id_ready,
        output fetch_ready, id_valid, PC_IFID_out, PC_plus4_IFID_out,
        output instruction_IFID_out, ecall_halt, occupancy
    );
endinterface

// File: rtl/ifid_perf_cnt.sv
// Free-running 32-bit event counters for the IF/ID queue (only used when
// IFID_PERF_CNT_EN is defined). Each counter wraps naturally at 2^32.
module ifid_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_evt,
    input  logic        flush_evt,
    input  logic        issue_evt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] issue_cnt
);

    // Count one per cycle for each event that is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
            if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
            if (issue_evt) issue_cnt <= issue_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling FIFO between fetch and decode.
// Holds {PC, PC+4, instruction} triples, supports flush and an ECALL fence
// that stops fetch until the next flush. fetch_ready depends only on
// registered state so it can drive fetch's PC_enable without a loop through
// decode. Optional macro IFID_PERF_CNT_EN adds stall/flush/issue counters.
module ifid_queue
    import ifid_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    ifid_queue_if.slave bus
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] issue_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    ifid_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             halt_q;
    logic             empty;
    logic             push;
    logic             pop;
    ifid_entry_t      wr_entry;

    assign empty           = (occ == '0);
    assign bus.fetch_ready = (occ != FULL_OCC) && !halt_q;
    assign bus.id_valid    = !empty;
    assign bus.ecall_halt  = halt_q;
    assign bus.occupancy   = occ;

    assign push = bus.fetch_valid & bus.fetch_ready & !bus.flush;
    assign pop  = bus.id_valid & bus.id_ready & !bus.flush;

    assign wr_entry.pc       = bus.PC_IFID_in;
    assign wr_entry.pc_plus4 = bus.PC_plus4_IFID_in;
    assign wr_entry.instr    = bus.instruction_IFID_in;

    // Present the head entry, or a zero-PC NOP bubble when empty.
    always_comb begin
        bus.PC_IFID_out          = '0;
        bus.PC_plus4_IFID_out    = '0;
        bus.instruction_IFID_out = NOP_INSTR;
        if (!empty) begin
            bus.PC_IFID_out          = mem[rd_ptr].pc;
            bus.PC_plus4_IFID_out    = mem[rd_ptr].pc_plus4;
            bus.instruction_IFID_out = mem[rd_ptr].instr;
        end
    end

    // Storage array; contents are qualified by occupancy so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Pointers, occupancy and the ECALL fence; flush outranks push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            halt_q <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            halt_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      occ <= occ + OCC_W'(1);
            else if (pop && !push) occ <= occ - OCC_W'(1);
            if (push && (bus.instruction_IFID_in == ECALL_INSTR)) halt_q <= 1'b1;
        end
    end

`ifdef IFID_PERF_CNT_EN
    ifid_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_evt (bus.fetch_valid & !bus.fetch_ready),
        .flush_evt (bus.flush),
        .issue_evt (pop),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .issue_cnt (issue_cnt)
    );
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// Directed self-checking bench for ifid_queue (DEPTH=2, XLEN=32).
module tb_ifid_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] issue_cnt;
`endif

    ifid_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    ifid_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .issue_cnt (issue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tagged with its PC; low byte 0x93 keeps it distinct from ECALL.
    function automatic logic [31:0] insnFor(input logic [31:0] pc);
        return 32'h00100093 + (pc << 20);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic fl, input logic rdy);
        bus.fetch_valid         = fv;
        bus.PC_IFID_in          = pc;
        bus.PC_plus4_IFID_in    = pc + 32'd4;
        bus.instruction_IFID_in = instr;
        bus.flush               = fl;
        bus.id_ready            = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [31:0] pc);
        checkOutput({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd1);
        checkOutput({tag, "_pc"},    bus.PC_IFID_out, pc);
        checkOutput({tag, "_pc4"},   bus.PC_plus4_IFID_out, pc + 32'd4);
        checkOutput({tag, "_insn"},  bus.instruction_IFID_out, insnFor(pc));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd0);
        checkOutput({tag, "_occ"},   32'(bus.occupancy), 32'd0);
        checkOutput({tag, "_insn"},  bus.instruction_IFID_out, 32'h00000013);
        checkOutput({tag, "_pc"},    bus.PC_IFID_out, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset state
        #12;
        checkEmpty("reset");
        checkOutput("reset_fready", {31'd0, bus.fetch_ready}, 32'd1);
        checkOutput("reset_halt",   {31'd0, bus.ecall_halt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fill: push 0x0, 0x4, then 0x8 must be held upstream
        applyStimulus(1'b1, 32'h0, insnFor(32'h0), 1'b0, 1'b0);
        step();
        checkOutput("fill1_occ", 32'(bus.occupancy), 32'd1);
        checkHead("fill1_head", 32'h0);
        applyStimulus(1'b1, 32'h4, insnFor(32'h4), 1'b0, 1'b0);
        step();
        checkOutput("fill2_occ", 32'(bus.occupancy), 32'd2);
        checkOutput("fill2_fready", {31'd0, bus.fetch_ready}, 32'd0);
        applyStimulus(1'b1, 32'h8, insnFor(32'h8), 1'b0, 1'b0);
        step();
        checkOutput("full_hold_occ", 32'(bus.occupancy), 32'd2);
        checkHead("full_hold_head", 32'h0);

        // Drain in order; 0x8 enters once space frees up
        applyStimulus(1'b1, 32'h8, insnFor(32'h8), 1'b0, 1'b1);
        checkHead("drain0", 32'h0);
        step();
        checkOutput("drain0_occ", 32'(bus.occupancy), 32'd1);
        checkOutput("drain0_fready", {31'd0, bus.fetch_ready}, 32'd1);
        checkHead("drain1", 32'h4);
        step();
        checkOutput("drain1_occ", 32'(bus.occupancy), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkHead("drain2", 32'h8);
        step();
        checkEmpty("drained");
        step();
        checkEmpty("empty_pop_no_underflow");

        // Simultaneous push and pop at occupancy 1
        applyStimulus(1'b1, 32'h8, insnFor(32'h8), 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hC, insnFor(32'hC), 1'b0, 1'b1);
        checkHead("pp_before", 32'h8);
        step();
        checkOutput("pp_occ", 32'(bus.occupancy), 32'd1);
        checkHead("pp_after", 32'hC);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        checkEmpty("pp_drained");

        // Flush with a full queue and a same-cycle fetch
        applyStimulus(1'b1, 32'h20, insnFor(32'h20), 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h24, insnFor(32'h24), 1'b0, 1'b0);
        step();
        checkOutput("preflush_occ", 32'(bus.occupancy), 32'd2);
        applyStimulus(1'b1, 32'h28, insnFor(32'h28), 1'b1, 1'b1);
        step();
        checkEmpty("flush");
        checkOutput("flush_fready", {31'd0, bus.fetch_ready}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        checkEmpty("flush_triple_absent");

        // ECALL fence
        applyStimulus(1'b1, 32'h10, 32'h00000073, 1'b0, 1'b0);
        step();
        checkOutput("ecall_halt", {31'd0, bus.ecall_halt}, 32'd1);
        checkOutput("ecall_fready", {31'd0, bus.fetch_ready}, 32'd0);
        applyStimulus(1'b1, 32'h14, insnFor(32'h14), 1'b0, 1'b1);
        checkOutput("ecall_head_insn", bus.instruction_IFID_out, 32'h00000073);
        checkOutput("ecall_head_pc", bus.PC_IFID_out, 32'h10);
        step();
        checkEmpty("ecall_fenced");
        checkOutput("ecall_halt_sticky", {31'd0, bus.ecall_halt}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("ecall_flush_halt", {31'd0, bus.ecall_halt}, 32'd0);
        checkOutput("ecall_flush_fready", {31'd0, bus.fetch_ready}, 32'd1);

        // Pointer wrap: 3*DEPTH back-to-back push/pop pairs
        applyStimulus(1'b1, 32'h100, insnFor(32'h100), 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic [31:0] nxt;
            nxt = 32'h100 + 32'(4 * (i + 1));
            applyStimulus(1'b1, nxt, insnFor(nxt), 1'b0, 1'b1);
            checkHead($sformatf("wrap%0d", i), 32'h100 + 32'(4 * i));
            step();
            checkOutput($sformatf("wrap%0d_occ", i), 32'(bus.occupancy), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkHead("wrap_last", 32'h100 + 32'(4 * 3 * DEPTH));
        step();
        checkEmpty("wrap_drained");

        // Asynchronous reset mid-operation drops everything at once
        applyStimulus(1'b1, 32'h200, insnFor(32'h200), 1'b0, 1'b0);
        step();
        checkOutput("prereset_occ", 32'(bus.occupancy), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkEmpty("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
